// File: rtl/smm258_final_sub.sv
// rtl/smm258_final_sub.sv - Montgomery final conditional subtract, two-stage split 258-bit pipeline
// Optional feature macro: SMM_FINAL_SUB_RANGE_CHECK_EN adds range_err (t_in >= 2N flag).
module smm258_final_sub (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [258:0] t_in,
  input  logic [257:0] n_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [257:0] out,
  output logic         sub_taken
`ifdef SMM_FINAL_SUB_RANGE_CHECK_EN
  ,
  output logic         range_err
`endif
);

  // Stage 1 holds the low-half difference and its borrow plus the upper operands.
  logic         s1_valid;
  logic [128:0] s1_diff_lo;
  logic         s1_borrow;
  logic [128:0] s1_t_lo;
  logic [129:0] s1_t_hi;
  logic [128:0] s1_n_hi;
`ifdef SMM_FINAL_SUB_RANGE_CHECK_EN
  logic [128:0] s1_n_lo;
`endif

  logic en1;
  logic en2;

  // Output register only moves when empty or drained; s1 moves when it can hand over.
  assign en2      = !out_valid || out_ready;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1;

  // Low half: extra MSB of the 130-bit result is the borrow into the high half.
  logic [129:0] lo_sub;
  assign lo_sub = {1'b0, t_in[128:0]} - {1'b0, n_in[128:0]};

  // High half: 130-bit operands widened by one so bit 130 is the final borrow.
  logic [130:0] hi_sub;
  logic         ge;
  logic [257:0] out_next;
  assign hi_sub   = {1'b0, s1_t_hi} - {2'b00, s1_n_hi} - {130'd0, s1_borrow};
  assign ge       = !hi_sub[130];
  assign out_next = ge ? {hi_sub[128:0], s1_diff_lo} : {s1_t_hi[128:0], s1_t_lo};

`ifdef SMM_FINAL_SUB_RANGE_CHECK_EN
  // t >= 2N exactly when the subtracted result t-N is still >= N.
  logic [258:0] diff_full;
  logic         range_next;
  assign diff_full  = {hi_sub[129:0], s1_diff_lo};
  assign range_next = ge && (diff_full >= {1'b0, s1_n_hi, s1_n_lo});
`else
  logic unused_hi;
  assign unused_hi = hi_sub[129];
`endif

  // Stage 1 register: accept a new operand pair whenever en1 allows.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_diff_lo <= '0;
      s1_borrow  <= 1'b0;
      s1_t_lo    <= '0;
      s1_t_hi    <= '0;
      s1_n_hi    <= '0;
`ifdef SMM_FINAL_SUB_RANGE_CHECK_EN
      s1_n_lo    <= '0;
`endif
    end else if (en1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_diff_lo <= lo_sub[128:0];
        s1_borrow  <= lo_sub[129];
        s1_t_lo    <= t_in[128:0];
        s1_t_hi    <= t_in[258:129];
        s1_n_hi    <= n_in[257:129];
`ifdef SMM_FINAL_SUB_RANGE_CHECK_EN
        s1_n_lo    <= n_in[128:0];
`endif
      end
    end
  end

  // Stage 2 register: finish the high half, select, and hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      sub_taken <= 1'b0;
`ifdef SMM_FINAL_SUB_RANGE_CHECK_EN
      range_err <= 1'b0;
`endif
    end else if (en2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out       <= out_next;
        sub_taken <= ge;
`ifdef SMM_FINAL_SUB_RANGE_CHECK_EN
        range_err <= range_next;
`endif
      end
    end
  end

endmodule
